// File: rtl/if_id_queue_pkg.sv
// Shared defines for the IF/ID fetch queue: bus widths, zero word, reset level
// and the per-cycle queue operation encoding.
package if_id_queue_pkg;

  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b0;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_PUSH,
    OP_POP,
    OP_SWAP,
    OP_FLUSH
  } q_op_e;

  // flush dominates; otherwise the push/pop pair selects the pointer update
  function automatic q_op_e decode_op(input logic flush, input logic push, input logic pop);
    q_op_e op;
    if (flush) begin
      op = OP_FLUSH;
    end else begin
      unique case ({push, pop})
        2'b10:   op = OP_PUSH;
        2'b01:   op = OP_POP;
        2'b11:   op = OP_SWAP;
        default: op = OP_HOLD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle; master is the pipeline side that offers,
// consumes and flushes, slave is the queue itself.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int AW = InstAddrBus,
  parameter int IW = InstBus
);

  logic          flush;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [IW-1:0] if_inst;
  logic          if_ready;
  logic          id_valid;
  logic [AW-1:0] id_pc;
  logic [IW-1:0] id_inst;
  logic          id_ready;

  modport master (
    output flush, if_valid, if_pc, if_inst, id_ready,
    input  if_ready, id_valid, id_pc, id_inst
  );

  modport slave (
    input  flush, if_valid, if_pc, if_inst, id_ready,
    output if_ready, id_valid, id_pc, id_inst
  );

endinterface

// File: rtl/if_id_mem.sv
// Fetch-buffer storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the control logic masks empty slots.
module if_id_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int IW    = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [AW-1:0] wpc,
  input  logic [IW-1:0] winst,
  input  logic [PW-1:0] raddr,
  output logic [AW-1:0] rpc,
  output logic [IW-1:0] rinst
);

  logic [AW+IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {wpc, winst};
    end
  end

  assign {rpc, rinst} = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID fetch queue: DEPTH-entry FIFO between fetch and decode with registered
// ready/valid flags, flush redirect and zero-bubble output when empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = InstAddrBus,
  parameter int IW    = InstBus,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  bus,
  output logic [CW-1:0] count
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FullCnt  = CW'(DEPTH);
  localparam logic [AW-1:0] PcZero   = AW'(ZeroWord);
  localparam logic [IW-1:0] InstZero = IW'(ZeroWord);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          if_ready_q;
  logic          id_valid_q;
  logic          push;
  logic          pop;
  q_op_e         op;
  logic [CW-1:0] count_nxt;
  logic [AW-1:0] head_pc;
  logic [IW-1:0] head_inst;

  always_comb begin
    push      = bus.if_valid && if_ready_q && !bus.flush;
    pop       = id_valid_q && bus.id_ready && !bus.flush;
    op        = decode_op(bus.flush, push, pop);
    count_nxt = count;
    unique case (op)
      OP_PUSH:  count_nxt = count + 1'b1;
      OP_POP:   count_nxt = count - 1'b1;
      OP_FLUSH: count_nxt = '0;
      default:  count_nxt = count;
    endcase
  end

  // Flags are registered from the next count so if_ready never sees id_ready
  // combinationally and a fresh entry only becomes visible a cycle later.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      if_ready_q <= 1'b1;
      id_valid_q <= 1'b0;
    end else begin
      count      <= count_nxt;
      if_ready_q <= (count_nxt != FullCnt);
      id_valid_q <= (count_nxt != '0);
      unique case (op)
        OP_FLUSH: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
        OP_PUSH: wr_ptr <= wr_ptr + 1'b1;
        OP_POP:  rd_ptr <= rd_ptr + 1'b1;
        OP_SWAP: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  if_id_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wpc   (bus.if_pc),
    .winst (bus.if_inst),
    .raddr (rd_ptr),
    .rpc   (head_pc),
    .rinst (head_inst)
  );

  assign bus.if_ready = if_ready_q;
  assign bus.id_valid = id_valid_q;
  assign bus.id_pc    = id_valid_q ? head_pc   : PcZero;
  assign bus.id_inst  = id_valid_q ? head_inst : InstZero;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4): reset, fill/overflow, drain order,
// full-with-pop, flush, streaming wrap-around and mid-operation reset.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [CW-1:0] count;
  int            total;
  int            bad;

  if_id_queue_if #(.AW(AW), .IW(IW)) bus ();

  if_id_queue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW),
    .CW    (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; checks happen there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ir);
    bus.flush    = fl;
    bus.if_valid = iv;
    bus.if_pc    = pc;
    bus.if_inst  = pc ^ 32'hA5A5_0000;
    bus.id_ready = ir;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_id_valid"}, 64'(bus.id_valid), 64'd0);
    chk({tag, "_id_pc"}, 64'(bus.id_pc), 64'd0);
    chk({tag, "_id_inst"}, 64'(bus.id_inst), 64'd0);
    chk({tag, "_if_ready"}, 64'(bus.if_ready), 64'd1);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_id_valid"}, 64'(bus.id_valid), 64'd1);
    chk({tag, "_id_pc"}, 64'(bus.id_pc), 64'(pc));
    chk({tag, "_id_inst"}, 64'(bus.id_inst), 64'(pc ^ 32'hA5A5_0000));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    step();
    chk_empty("reset");
    rst = 1'b1;

    // three pushes with decode stalled; first entry not visible in its own cycle
    drive(1'b0, 1'b1, 32'h100, 1'b0);
    chk("nobypass_valid", 64'(bus.id_valid), 64'd0);
    chk("nobypass_pc", 64'(bus.id_pc), 64'd0);
    step();
    chk_head("push1", 32'h100);
    chk("push1_count", 64'(count), 64'd1);
    drive(1'b0, 1'b1, 32'h104, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h108, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("push3_count", 64'(count), 64'd3);
    chk_head("push3_stable", 32'h100);
    chk("push3_if_ready", 64'(bus.if_ready), 64'd1);

    // fill to DEPTH, then a fifth offer must be refused
    drive(1'b0, 1'b1, 32'h10C, 1'b0);
    step();
    chk("full_count", 64'(count), 64'd4);
    chk("full_if_ready", 64'(bus.if_ready), 64'd0);
    drive(1'b0, 1'b1, 32'h110, 1'b0);
    step();
    chk("overflow_count", 64'(count), 64'd4);
    chk_head("overflow_head", 32'h100);

    // drain in push order
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk_head($sformatf("drain%0d", i), 32'h100 + 32'(4 * i));
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_empty("drained");

    // full queue, offer and consume together: pop only
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'h200 + 32'(4 * i), 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 32'h300, 1'b1);
    chk("fullpop_if_ready_before", 64'(bus.if_ready), 64'd0);
    step();
    chk("fullpop_count", 64'(count), 64'd3);
    chk("fullpop_if_ready_after", 64'(bus.if_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk_head($sformatf("fullpop_drain%0d", i), 32'h200 + 32'(4 * i));
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_empty("fullpop_empty");

    // flush with two entries while offering and consuming
    drive(1'b0, 1'b1, 32'h400, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h404, 1'b0);
    step();
    chk("preflush_count", 64'(count), 64'd2);
    drive(1'b1, 1'b1, 32'h500, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_empty("flush");
    step();
    chk_empty("flush_dropped");
    drive(1'b0, 1'b1, 32'h600, 1'b0);
    step();
    chk_head("postflush", 32'h600);
    chk("postflush_count", 64'(count), 64'd1);

    // simultaneous push and pop at count==1
    drive(1'b0, 1'b1, 32'h604, 1'b1);
    step();
    chk("swap1_count", 64'(count), 64'd1);
    chk_head("swap1", 32'h604);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_empty("swap1_empty");

    // streaming at count==2 for 3*DEPTH cycles; pointers wrap several times
    drive(1'b0, 1'b1, 32'h700, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h704, 1'b0);
    step();
    for (int k = 0; k < 3 * DEPTH; k++) begin
      drive(1'b0, 1'b1, 32'h708 + 32'(4 * k), 1'b1);
      chk("stream_pc", 64'(bus.id_pc), 64'(32'h700 + 32'(4 * k)));
      step();
      chk("stream_count", 64'(count), 64'd2);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk_head($sformatf("stream_tail%0d", k), 32'h730 + 32'(4 * k));
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_empty("stream_empty");

    // reset with three entries, overriding a concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h800 + 32'(4 * i), 1'b0);
      step();
    end
    chk("prerst_count", 64'(count), 64'd3);
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h8F0, 1'b1);
    step();
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h900, 1'b0);
    chk_empty("midrst");
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_head("afterrst", 32'h900);
    chk("afterrst_count", 64'(count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of fetch-buffer entries; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter AW, default 32, width of instruction address.
REQ-003 SHALL have parameter IW, default 32, width of instruction word.
REQ-004 SHALL have parameter CW, default $clog2(DEPTH)+1, width of occupancy count.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low (rst==0 resets on the next rising clk).
REQ-007 flush  in  1  branch/exception redirect; discard every buffered entry.
REQ-008 if_valid  in  1  fetch stage offers an entry this cycle.
REQ-009 if_pc  in  AW  address of the offered instruction.
REQ-010 if_inst  in  IW  offered instruction word.
REQ-011 if_ready  out  1  queue accepts an entry this cycle; registered, equals (count != DEPTH).
REQ-012 id_valid  out  1  head entry present; registered, equals (count != 0).
REQ-013 id_pc  out  AW  head entry address; all-zero when id_valid==0.
REQ-014 id_inst  out  IW  head entry instruction; all-zero (NOP bubble) when id_valid==0.
REQ-015 id_ready  in  1  decode consumes the head entry this cycle (decode not stalled).
REQ-016 count  out  CW  current occupancy, 0..DEPTH.

Function
REQ-017 Push occurs iff if_valid && if_ready && !flush; pop occurs iff id_valid && id_ready && !flush.
REQ-018 A pushed entry SHALL be visible on id_* no earlier than the next cycle; there is no write-to-read bypass (minimum latency 1 clk).
REQ-019 Entries SHALL leave in strict push order (FIFO).
REQ-020 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers, including at count==1.
REQ-021 When full, if_ready==0 even if id_ready==1 in that cycle; no combinational path from id_ready to if_ready.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-023 flush SHALL have priority over push and pop: next cycle count==0, pointers==0, id_valid==0, id_pc/id_inst zero, if_ready==1; the entry offered during the flush cycle is dropped.
REQ-024 id_pc/id_inst SHALL remain stable while id_valid==1 and id_ready==0.
REQ-025 if_valid while if_ready==0 SHALL not alter state; the offer is not stored.

Reset
REQ-026 While rst==0 at a rising edge: count=0, pointers=0, id_valid=0, if_ready=1, id_pc=ZeroWord, id_inst=ZeroWord.
REQ-027 Reset SHALL override flush, push and pop, and discard all entries when asserted mid-operation.
REQ-028 Storage array contents need not be reset; no stale entry SHALL ever reach id_* after reset or flush.

Structure
REQ-029 Bus-width constants (InstAddrBus, InstBus), ZeroWord and the reset-active level SHALL come from the shared defines file; the active-low reset level constant SHALL be defined there.
REQ-030 Storage SHALL be a sub-module if_id_mem (DEPTH x (AW+IW), one synchronous write port, asynchronous read port); pointer/count control stays in if_id_queue.

Verification
REQ-031 Reset then push 3 entries (pc 0x100/0x104/0x108), id_ready=0 -> count=3, id_pc=0x100 stable, if_ready=1.
REQ-032 DEPTH=4: push 5 back-to-back, id_ready=0 -> count=4, if_ready=0 after 4th, 5th entry not stored; then pop all -> order 0x100..0x10C, then id_valid=0, id_inst=0.
REQ-033 Full queue with if_valid=1, id_ready=1 same cycle -> pop only, count 4->3, if_ready=1 next cycle.
REQ-034 count=2, flush=1 with if_valid=1, id_ready=1 -> next cycle count=0, id_valid=0, id_pc=0, if_ready=1.
REQ-035 Continuous push/pop for 3*DEPTH cycles -> count constant, pointers wrap, no loss or reorder.
REQ-036 rst=0 asserted with count=3 -> next cycle all outputs at reset values; first push after release appears at id_* one cycle later.
